// File: rtl/soc.sv
// soc: single-core RV32I system-on-chip.
// A multi-cycle core runs from an on-chip RAM preloaded with an LED-counter
// program. Stores to 0x0040_0004 update a 5-bit LED register.
// Ports:
//   clk    - system clock, rising edge
//   resetn - asynchronous reset, active HIGH (1 holds the SoC in reset)
//   LEDS   - registered LED value
//   RXD    - UART receive, ignored in this revision
//   TXD    - UART transmit, held at 1
module soc #(
    parameter int unsigned MEM_WORDS = 256,
    parameter logic [31:0] INIT_IMAGE [MEM_WORDS] = '{
        0:       32'h0000_0093,  // addi x1,x0,0
        1:       32'h0040_0137,  // lui  x2,0x400
        2:       32'h0010_8093,  // addi x1,x1,1
        3:       32'h0011_2223,  // sw   x1,4(x2)
        4:       32'hFF9F_F06F,  // jal  x0,-8
        default: 32'h0000_0000
    }
) (
    input  logic       clk,
    input  logic       resetn,
    output logic [4:0] LEDS,
    input  logic       RXD,
    output logic       TXD
);

    localparam int unsigned AW = $clog2(MEM_WORDS);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FETCH_INSTR,
        WAIT_INSTR,
        EXECUTE,
        LOAD,
        WAIT_DATA,
        STORE
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic [4:0]  leds_q, leds_d;

    logic [31:0] rf_q [32];
    logic [31:0] mem_q [MEM_WORDS] = INIT_IMAGE;
    logic [31:0] rdata_q;

    // Instruction fields and immediates
    logic [6:0]  opcode_c;
    logic [4:0]  rd_c;
    logic [2:0]  funct3_c;
    logic        alt_c;
    logic [31:0] imm_i_c, imm_s_c, imm_b_c, imm_u_c, imm_j_c;

    assign opcode_c = instr_q[6:0];
    assign rd_c     = instr_q[11:7];
    assign funct3_c = instr_q[14:12];
    assign alt_c    = instr_q[30];
    assign imm_i_c  = {{20{instr_q[31]}}, instr_q[31:20]};
    assign imm_s_c  = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
    assign imm_b_c  = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                       instr_q[11:8], 1'b0};
    assign imm_u_c  = {instr_q[31:12], 12'h000};
    assign imm_j_c  = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                       instr_q[30:21], 1'b0};

    // ALU: register or immediate second operand, single-cycle barrel shifter
    logic [31:0] op_b_c;
    logic [4:0]  shamt_c;
    logic [31:0] alu_c;

    assign op_b_c  = (opcode_c == OPC_OP) ? rs2_q : imm_i_c;
    assign shamt_c = op_b_c[4:0];

    always_comb begin
        alu_c = '0;
        case (funct3_c)
            3'd0:    alu_c = (opcode_c == OPC_OP && alt_c) ? rs1_q - op_b_c : rs1_q + op_b_c;
            3'd1:    alu_c = rs1_q << shamt_c;
            3'd2:    alu_c = {31'd0, $signed(rs1_q) < $signed(op_b_c)};
            3'd3:    alu_c = {31'd0, rs1_q < op_b_c};
            3'd4:    alu_c = rs1_q ^ op_b_c;
            3'd5:    alu_c = alt_c ? 32'($signed(rs1_q) >>> shamt_c) : rs1_q >> shamt_c;
            3'd6:    alu_c = rs1_q | op_b_c;
            default: alu_c = rs1_q & op_b_c;
        endcase
    end

    // Branch decision
    logic take_c;

    always_comb begin
        take_c = 1'b0;
        case (funct3_c)
            3'd0:    take_c = rs1_q == rs2_q;
            3'd1:    take_c = rs1_q != rs2_q;
            3'd4:    take_c = $signed(rs1_q) < $signed(rs2_q);
            3'd5:    take_c = $signed(rs1_q) >= $signed(rs2_q);
            3'd6:    take_c = rs1_q < rs2_q;
            3'd7:    take_c = rs1_q >= rs2_q;
            default: take_c = 1'b0;
        endcase
    end

    // Load/store address decode; stays valid through LOAD/WAIT_DATA/STORE
    // because instr_q and rs1_q hold until the next fetch.
    logic [31:0] ls_addr_c;
    logic        is_io_c;
    logic        led_sel_c;

    assign ls_addr_c = rs1_q + ((opcode_c == OPC_STORE) ? imm_s_c : imm_i_c);
    assign is_io_c   = ls_addr_c[22];
    assign led_sel_c = is_io_c && (ls_addr_c[21:2] == 20'd1);

    // Store lane placement
    logic [31:0] wdata_c;
    logic [3:0]  wmask_c;

    always_comb begin
        wdata_c = rs2_q;
        wmask_c = 4'b1111;
        case (funct3_c[1:0])
            2'd0: begin
                wdata_c = {4{rs2_q[7:0]}};
                wmask_c = 4'b0001 << ls_addr_c[1:0];
            end
            2'd1: begin
                wdata_c = {2{rs2_q[15:0]}};
                wmask_c = ls_addr_c[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_c = rs2_q;
                wmask_c = 4'b1111;
            end
        endcase
    end

    // Load lane select and extension; IO reads return 0
    logic [31:0] byte_c, half_c, load_c;

    assign byte_c = rdata_q >> {ls_addr_c[1:0], 3'b000};
    assign half_c = rdata_q >> {ls_addr_c[1], 4'b0000};

    always_comb begin
        load_c = rdata_q;
        case (funct3_c)
            3'd0:    load_c = {{24{byte_c[7]}}, byte_c[7:0]};
            3'd1:    load_c = {{16{half_c[15]}}, half_c[15:0]};
            3'd4:    load_c = {24'd0, byte_c[7:0]};
            3'd5:    load_c = {16'd0, half_c[15:0]};
            default: load_c = rdata_q;
        endcase
        if (is_io_c) begin
            load_c = '0;
        end
    end

    // RAM port: instruction fetch or data access, one per cycle
    logic [AW-1:0] ram_idx_c;
    logic          ram_re_c;
    logic          ram_we_c;

    assign ram_idx_c = (state_q == FETCH_INSTR) ? pc_q[AW+1:2] : ls_addr_c[AW+1:2];
    assign ram_re_c  = (state_q == FETCH_INSTR) || (state_q == LOAD && !is_io_c);
    assign ram_we_c  = (state_q == STORE) && !is_io_c && !resetn;

    // Core sequencing, writeback and PC update
    logic        rf_we_c;
    logic [31:0] rf_wdata_c;
    logic [31:0] pc_plus4_c;

    assign pc_plus4_c = pc_q + 32'd4;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        leds_d     = leds_q;
        rf_we_c    = 1'b0;
        rf_wdata_c = '0;
        case (state_q)
            FETCH_INSTR: state_d = WAIT_INSTR;
            WAIT_INSTR: begin
                instr_d = rdata_q;
                rs1_d   = (rdata_q[19:15] == 5'd0) ? '0 : rf_q[rdata_q[19:15]];
                rs2_d   = (rdata_q[24:20] == 5'd0) ? '0 : rf_q[rdata_q[24:20]];
                state_d = EXECUTE;
            end
            EXECUTE: begin
                state_d = FETCH_INSTR;
                pc_d    = pc_plus4_c;
                case (opcode_c)
                    OPC_LUI: begin
                        rf_we_c    = 1'b1;
                        rf_wdata_c = imm_u_c;
                    end
                    OPC_AUIPC: begin
                        rf_we_c    = 1'b1;
                        rf_wdata_c = pc_q + imm_u_c;
                    end
                    OPC_JAL: begin
                        rf_we_c    = 1'b1;
                        rf_wdata_c = pc_plus4_c;
                        pc_d       = pc_q + imm_j_c;
                    end
                    OPC_JALR: begin
                        rf_we_c    = 1'b1;
                        rf_wdata_c = pc_plus4_c;
                        pc_d       = (rs1_q + imm_i_c) & 32'hFFFF_FFFE;
                    end
                    OPC_BRANCH: begin
                        if (take_c) begin
                            pc_d = pc_q + imm_b_c;
                        end
                    end
                    OPC_OPIMM, OPC_OP: begin
                        rf_we_c    = 1'b1;
                        rf_wdata_c = alu_c;
                    end
                    OPC_LOAD:  state_d = LOAD;
                    OPC_STORE: state_d = STORE;
                    default: ;
                endcase
            end
            LOAD: state_d = WAIT_DATA;
            WAIT_DATA: begin
                rf_we_c    = 1'b1;
                rf_wdata_c = load_c;
                state_d    = FETCH_INSTR;
            end
            STORE: begin
                if (led_sel_c) begin
                    leds_d = rs2_q[4:0];
                end
                state_d = FETCH_INSTR;
            end
            default: state_d = FETCH_INSTR;
        endcase
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q <= FETCH_INSTR;
            pc_q    <= '0;
            instr_q <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            leds_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            leds_q  <= leds_d;
        end
    end

    // Register file: not reset; x0 is never written
    always_ff @(posedge clk) begin
        if (rf_we_c && rd_c != 5'd0) begin
            rf_q[rd_c] <= rf_wdata_c;
        end
    end

    // Synchronous-read RAM with byte enables; keeps its image across reset
    always_ff @(posedge clk) begin
        if (ram_re_c) begin
            rdata_q <= mem_q[ram_idx_c];
        end
        if (ram_we_c && wmask_c[0]) mem_q[ram_idx_c][7:0]   <= wdata_c[7:0];
        if (ram_we_c && wmask_c[1]) mem_q[ram_idx_c][15:8]  <= wdata_c[15:8];
        if (ram_we_c && wmask_c[2]) mem_q[ram_idx_c][23:16] <= wdata_c[23:16];
        if (ram_we_c && wmask_c[3]) mem_q[ram_idx_c][31:24] <= wdata_c[31:24];
    end

    assign LEDS = leds_q;
    assign TXD  = 1'b1;

    // RXD is reserved; upper address bits are don't-care for decode
    logic unused_c;
    assign unused_c = ^{RXD, ls_addr_c};

endmodule

// File: tb/tb_soc.sv
// tb_soc: checks the built-in LED counter against an edge-count model under
// randomized reset timing, and runs an alternate program image that reports
// ALU/branch/load/store/IO results through the LED register.
module tb_soc;

    // Instruction encoders for building the alternate image
    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction
    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
        logic [11:0] i;
        i = 12'(imm);
        return {i[11:5], 5'(rs2), 5'(rs1), 3'(f3), i[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(int off, int rs2, int rs1, int f3);
        logic [12:0] i;
        i = 13'(off);
        return {i[12], i[10:5], 5'(rs2), 5'(rs1), 3'(f3), i[4:1], i[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_u(int imm20, int rd, int op);
        return {20'(imm20), 5'(rd), 7'(op)};
    endfunction
    function automatic logic [31:0] enc_j(int off, int rd);
        logic [20:0] i;
        i = 21'(off);
        return {i[20], i[10:1], i[11], i[19:12], 5'(rd), 7'h6F};
    endfunction

    localparam logic [31:0] ALT_IMAGE [256] = '{
        0:  enc_u(32'h400, 2, 'h37),            // x2 = IO base
        1:  enc_i('h80, 0, 0, 3, 'h13),         // x3 = 0x80
        2:  enc_i('h200, 0, 0, 4, 'h13),        // x4 = data base
        3:  enc_s(1, 3, 4, 0),                  // sb x3,1(x4)
        4:  enc_i(1, 4, 0, 5, 'h03),            // lb
        5:  enc_i(1, 4, 4, 6, 'h03),            // lbu
        6:  enc_i(27, 5, 5, 7, 'h13),           // srli -> 31
        7:  enc_s(4, 7, 2, 2),
        8:  enc_i(3, 6, 5, 8, 'h13),            // srli -> 16
        9:  enc_s(4, 8, 2, 2),
        10: enc_u(32'h80000, 9, 'h37),
        11: enc_i('h404, 9, 5, 10, 'h13),       // srai by 4
        12: enc_i(26, 10, 5, 11, 'h13),         // -> 30
        13: enc_s(4, 11, 2, 2),
        14: enc_i(-1, 0, 0, 12, 'h13),          // x12 = -1
        15: enc_i(1, 0, 0, 13, 'h13),           // x13 = 1
        16: enc_b(208, 13, 12, 6),              // bltu -1,1 must not branch
        17: enc_i(5, 0, 0, 14, 'h13),
        18: enc_b(8, 12, 13, 6),                // bltu 1,-1 branches
        19: enc_i(9, 0, 0, 14, 'h13),
        20: enc_s(4, 14, 2, 2),                 // -> 5
        21: enc_r('h20, 12, 13, 0, 16),         // sub -> 2
        22: enc_r(0, 13, 16, 1, 16),            // sll -> 4
        23: enc_r(0, 14, 16, 4, 16),            // xor -> 1
        24: enc_i(8, 16, 6, 16, 'h13),          // ori -> 9
        25: enc_s(4, 16, 2, 2),
        26: enc_r(0, 13, 12, 2, 17),            // slt  -> 1
        27: enc_r(0, 13, 12, 3, 18),            // sltu -> 0
        28: enc_i(0, 12, 2, 19, 'h13),          // slti -> 1
        29: enc_i(-1, 13, 3, 20, 'h13),         // sltiu -> 1
        30: enc_i(1, 18, 1, 18, 'h13),
        31: enc_i(2, 19, 1, 19, 'h13),
        32: enc_i(3, 20, 1, 20, 'h13),
        33: enc_r(0, 18, 17, 0, 21),
        34: enc_r(0, 19, 21, 6, 21),
        35: enc_r(0, 20, 21, 0, 21),
        36: enc_i(15, 21, 7, 21, 'h13),         // -> 13
        37: enc_s(4, 21, 2, 2),
        38: enc_s(2, 12, 4, 1),                 // sh upper half
        39: enc_i(2, 4, 5, 22, 'h03),           // lhu
        40: enc_i(2, 4, 1, 23, 'h03),           // lh
        41: enc_i(0, 4, 2, 24, 'h03),           // lw
        42: enc_i(12, 22, 5, 25, 'h13),
        43: enc_r(0, 23, 25, 0, 25),
        44: enc_i(15, 24, 5, 26, 'h13),
        45: enc_i(3, 26, 7, 26, 'h13),
        46: enc_r(0, 26, 25, 0, 25),            // -> 17
        47: enc_s(4, 25, 2, 2),
        48: enc_u(0, 27, 'h17),                 // auipc
        49: enc_i(12, 27, 0, 28, 'h67),         // jalr skips next
        50: enc_i(0, 0, 0, 28, 'h13),
        51: enc_r('h20, 27, 28, 0, 30),         // -> 8
        52: enc_b(8, 13, 12, 5),                // bge not taken
        53: enc_i(2, 30, 0, 30, 'h13),
        54: enc_b(8, 13, 12, 4),                // blt taken
        55: enc_i(16, 30, 0, 30, 'h13),
        56: enc_b(8, 12, 13, 1),                // bne taken
        57: enc_i(16, 30, 0, 30, 'h13),
        58: enc_b(8, 12, 13, 0),                // beq not taken
        59: enc_i(5, 30, 0, 30, 'h13),
        60: enc_b(8, 13, 12, 7),                // bgeu taken
        61: enc_i(16, 30, 0, 30, 'h13),
        62: enc_s(4, 30, 2, 2),                 // -> 15
        63: enc_s(8, 12, 2, 2),                 // store to other IO word
        64: enc_i(4, 2, 2, 15, 'h03),           // IO read -> 0
        65: enc_i(3, 15, 0, 15, 'h13),
        66: enc_s(4, 15, 2, 2),                 // -> 3
        67: enc_j(0, 0),
        68: enc_i('h15, 0, 0, 31, 'h13),        // wrong-branch trap -> 21
        69: enc_s(4, 31, 2, 2),
        70: enc_j(0, 0),
        default: 32'h0
    };

    localparam int ALT_N = 9;

    logic       clk = 1'b0;
    logic       rst_main;
    logic       rst_alt;
    logic       rxd;
    logic [4:0] leds_main, leds_alt;
    logic       txd_main, txd_alt;

    int n_cmp = 0;
    int n_err = 0;
    int since = 0;
    int alt_k = 0;
    logic [4:0] alt_prev = 5'd0;
    int alt_exp [ALT_N] = '{31, 16, 30, 5, 9, 13, 17, 15, 3};

    soc u_soc (
        .clk    (clk),
        .resetn (rst_main),
        .LEDS   (leds_main),
        .RXD    (rxd),
        .TXD    (txd_main)
    );

    soc #(.INIT_IMAGE(ALT_IMAGE)) u_alt (
        .clk    (clk),
        .resetn (rst_alt),
        .LEDS   (leds_alt),
        .RXD    (rxd),
        .TXD    (txd_alt)
    );

    always #5 clk = ~clk;

    // Rising edges since the main reset was released
    always @(posedge clk) begin
        if (rst_main) since <= 0;
        else          since <= since + 1;
    end

    // Built-in program: first write at edge 13, one per 10 edges, mod 32
    function automatic int exp_main();
        if (rst_main || since < 13) return 0;
        return ((since - 13) / 10 + 1) % 32;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        check("leds_main", 32'(leds_main), 32'(exp_main()));
        check("txd_main", 32'(txd_main), 32'd1);
        check("txd_alt", 32'(txd_alt), 32'd1);
        if (rst_alt) begin
            check("alt_reset", 32'(leds_alt), 32'd0);
        end else if (leds_alt != alt_prev) begin
            check("alt_led", 32'(leds_alt), (alt_k < ALT_N) ? 32'(alt_exp[alt_k]) : 32'(alt_prev));
            alt_k++;
            alt_prev = leds_alt;
        end
        rxd = 1'($urandom);
    endtask

    initial begin
        int hold;
        int run;
        rst_main = 1'b1;
        rst_alt  = 1'b1;
        rxd      = 1'b0;
        repeat (100) step();

        rst_alt = 1'b0;
        repeat (700) step();
        check("alt_writes", 32'(alt_k), 32'(ALT_N));

        for (int s = 0; s < 7; s++) begin
            hold = (s == 0) ? 2 : int'($urandom_range(1, 5));
            run  = (s == 0) ? 345 : int'($urandom_range(15, 400));
            rst_main = 1'b1;
            repeat (hold) step();
            rst_main = 1'b0;
            repeat (run) step();
            rst_main = 1'b1;
            #1;
            check("async_reset", 32'(leds_main), 32'd0);
        end
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
